mult_sched: RTL and testbench

Round-robin scheduler that shares one pipelined 25×18 signed multiplier among NREQ requesters. It accepts at most one operand pair per clock, drives the multiplier's pipeline-enable bit with the issue strobe, and carries the winner's ID down a tag pipeline of matching depth. It returns each 43-bit product to the originating requester. It sits between the trigger-processing clients and the DSP multiplier on the fast processing clock.

---
 rtl/mult_sched_pkg.sv | 21 ++
 rtl/mult_sched_if.sv | 23 ++
 rtl/mult_sched_rr_arbiter.sv | 34 +++
 rtl/mult_sched.sv | 105 ++++++++++
 tb/tb_mult_sched.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared constants, tag payload and helpers for the multiplier scheduler.
package mult_sched_pkg;

  localparam int unsigned A_W             = 25;
  localparam int unsigned B_W             = 18;
  localparam int unsigned P_W             = 43;
  localparam int unsigned DEFAULT_LATENCY = 3;
  localparam int unsigned ID_MAX_W        = 3;
  localparam int unsigned CNT_W           = 16;

  // One tag-pipe stage: owner of the operation travelling beside the multiplier.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int unsigned id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_sched_if.sv
// Requester-side operand/result bus of the multiplier scheduler.
interface mult_sched_if #(
  parameter int unsigned NREQ = 4
);

  logic [NREQ-1:0]                      req_valid;
  logic [NREQ*mult_sched_pkg::A_W-1:0]  req_a;
  logic [NREQ*mult_sched_pkg::B_W-1:0]  req_b;
  logic [NREQ-1:0]                      req_ready;
  logic [NREQ-1:0]                      res_valid;
  logic [mult_sched_pkg::P_W-1:0]       res_p;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_p
  );

endinterface

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest valid index at or above last+1, modulo N.
module rr_arbiter
  import mult_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]        req,
  input  logic                en,
  input  logic [id_w(N)-1:0]  last,
  output logic [N-1:0]        grant,
  output logic [id_w(N)-1:0]  grant_id
);

  localparam int unsigned IDW = id_w(N);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDW'((32'(last) + 32'd1 + k) % N);
      if (en && !found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one pipelined signed multiplier among NREQ requesters, returning each
// product to its owner via a tag pipe matched to the multiplier latency.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  mult_sched_if.slave      bus,
  output logic             mult_pipe_in,
  output logic [A_W-1:0]   mult_a,
  output logic [B_W-1:0]   mult_b,
  input  logic             mult_pipe_out,
  input  logic [P_W-1:0]   mult_p,
  output logic [CNT_W-1:0] op_count,
  output logic             tag_err
);

  localparam int unsigned IDW    = id_w(NREQ);
  localparam int unsigned MASK_W = $clog2(LATENCY + 2);

  logic [IDW-1:0]    last_grant;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic              issue_en;
  logic              xfer;
  logic [A_W-1:0]    sel_a;
  logic [B_W-1:0]    sel_b;
  tag_t              tag_q [0:LATENCY];
  logic [MASK_W-1:0] mask_cnt;

  assign issue_en = en && !rst;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req      (bus.req_valid),
    .en       (issue_en),
    .last     (last_grant),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;
  assign xfer          = |grant;

  // Winner's operand slice.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = bus.req_a[i*A_W +: A_W];
        sel_b = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  // Issue registers; operands hold when idle to avoid toggling the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= IDW'(NREQ - 1);
      mult_pipe_in <= 1'b0;
      mult_a       <= '0;
      mult_b       <= '0;
      op_count     <= '0;
    end else begin
      mult_pipe_in <= xfer;
      if (xfer) begin
        mult_a     <= sel_a;
        mult_b     <= sel_b;
        last_grant <= grant_id;
        op_count   <= op_count + CNT_W'(1);
      end
    end
  end

  // Tag pipe plus consistency check, masked while pre-reset products drain out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s <= LATENCY; s++) tag_q[s] <= '0;
      mask_cnt <= MASK_W'(LATENCY + 1);
      tag_err  <= 1'b0;
    end else begin
      tag_q[0] <= '{valid: xfer, id: ID_MAX_W'(grant_id)};
      for (int unsigned s = 1; s <= LATENCY; s++) tag_q[s] <= tag_q[s-1];
      if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - MASK_W'(1);
      end else if (mult_pipe_out != tag_q[LATENCY].valid) begin
        tag_err <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.res_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bus.res_valid[i] = tag_q[LATENCY].valid && (tag_q[LATENCY].id == ID_MAX_W'(i));
    end
  end

  assign bus.res_p = mult_p;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: reference arbitration/product model feeds an
// expectation queue that a separate monitor drains on every result strobe.
module tb_mult_sched;
  import mult_sched_pkg::*;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned LATENCY = 3;

  typedef struct {
    int             id;
    logic [P_W-1:0] p;
    int             due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic inj = 1'b0;
  logic             mult_pipe_in;
  logic [A_W-1:0]   mult_a;
  logic [B_W-1:0]   mult_b;
  logic             mult_pipe_out;
  logic [P_W-1:0]   mult_p;
  logic [CNT_W-1:0] op_count;
  logic             tag_err;

  mult_sched_if #(.NREQ(NREQ)) bus ();

  mult_sched #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .bus           (bus),
    .mult_pipe_in  (mult_pipe_in),
    .mult_a        (mult_a),
    .mult_b        (mult_b),
    .mult_pipe_out (mult_pipe_out),
    .mult_p        (mult_p),
    .op_count      (op_count),
    .tag_err       (tag_err)
  );

  always #5 clk = ~clk;

  // Environment: unreset pipelined DSP multiplier, LATENCY register stages.
  logic signed [P_W-1:0] env_prod;
  logic [LATENCY-1:0]    mv = '0;
  logic [P_W-1:0]        mp [LATENCY];
  assign env_prod = $signed(mult_a) * $signed(mult_b);
  always @(posedge clk) begin
    for (int k = LATENCY - 1; k > 0; k--) begin
      mv[k] <= mv[k-1];
      mp[k] <= mp[k-1];
    end
    mv[0] <= mult_pipe_in;
    mp[0] <= env_prod;
  end
  assign mult_pipe_out = mv[LATENCY-1] | inj;
  assign mult_p        = mp[LATENCY-1];

  int   edges  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb [$];
  int   m_last = NREQ - 1;
  int   m_ops  = 0;
  logic [A_W-1:0] op_a [NREQ];
  logic [B_W-1:0] op_b [NREQ];

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint x, y, p;
    x = longint'($signed(a));
    y = longint'($signed(b));
    p = x * y;
    return p[P_W-1:0];
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(0, 5))
        0: begin op_a[i] = 25'h1000000; op_b[i] = 18'h20000; end
        1: begin op_a[i] = '1;          op_b[i] = 18'h1FFFF; end
        2: begin op_a[i] = 25'h0FFFFFF; op_b[i] = '1;        end
        default: begin op_a[i] = A_W'($urandom); op_b[i] = B_W'($urandom); end
      endcase
    end
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic step(input logic [NREQ-1:0] vmask, input logic en_v);
    int w;
    logic [NREQ-1:0] exp_ready;
    bus.req_valid = vmask;
    en = en_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*A_W +: A_W] = op_a[i];
      bus.req_b[i*B_W +: B_W] = op_b[i];
    end
    @(negedge clk);
    w = -1;
    if (en_v) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (w < 0 && vmask[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (w >= 0) begin
      sb.push_back('{id: w, p: ref_mul(op_a[w], op_b[w]), due: edges + 1 + LATENCY});
      m_last = w;
      m_ops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_ops();
      step('0, 1'b1);
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    sb.delete();
    m_last = NREQ - 1;
    m_ops  = 0;
    bus.req_valid = '1;
    en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("ready_in_reset", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid != '0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: res_valid=%b with nothing outstanding (t=%0t)", bus.res_valid, $time);
      end else begin
        exp_t e;
        logic [NREQ-1:0] oh;
        e = sb.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        check("res_valid", 64'(bus.res_valid), 64'(oh));
        check("res_p", 64'(bus.res_p), 64'(e.p));
        check("res_cycle", 64'(edges), 64'(e.due));
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    rand_ops();
    @(posedge clk);
    #1;
    reset_dut(4);
    @(negedge clk);
    check("rst_op_count", 64'(op_count), 64'd0);
    check("rst_tag_err", 64'(tag_err), 64'd0);
    check("rst_pipe_in", 64'(mult_pipe_in), 64'd0);
    check("rst_mult_a", 64'(mult_a), 64'd0);
    check("rst_mult_b", 64'(mult_b), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    @(posedge clk);
    #1;

    // Single request from requester 2: 2^22 * 2^15.
    rand_ops();
    op_a[2] = 25'h0400000;
    op_b[2] = 18'h08000;
    step(4'b0100, 1'b1);
    idle(LATENCY + 2);
    check("single_op_count", 64'(op_count), 64'(m_ops));

    // All requesters valid: rotation from a fresh last_grant, with -1 * -1 on requester 1.
    reset_dut(2);
    for (int c = 0; c < 8; c++) begin
      rand_ops();
      op_a[1] = '1;
      op_b[1] = '1;
      step('1, 1'b1);
    end

    // en low with requests pending, then resume.
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      step('1, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      rand_ops();
      step('1, 1'b1);
    end
    idle(LATENCY + 2);
    check("rr_op_count", 64'(op_count), 64'(m_ops));

    // Reset two cycles after three back-to-back issues; nothing may come back.
    for (int c = 0; c < 3; c++) begin
      rand_ops();
      step(4'b0001, 1'b1);
    end
    idle(2);
    reset_dut(1);
    idle(LATENCY + 4);
    check("post_rst_op_count", 64'(op_count), 64'd0);
    check("post_rst_tag_err", 64'(tag_err), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 300; c++) begin
      rand_ops();
      step(NREQ'($urandom), ($urandom_range(0, 7) != 0));
    end
    idle(LATENCY + 3);
    check("drain_empty", 64'(sb.size()), 64'd0);
    check("rand_op_count", 64'(op_count), 64'(m_ops[CNT_W-1:0]));
    check("rand_tag_err", 64'(tag_err), 64'd0);

    // Spurious pipe-out pulse with an empty tag pipe.
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    idle(1);
    check("tag_err_set", 64'(tag_err), 64'd1);
    idle(5);
    check("tag_err_sticky", 64'(tag_err), 64'd1);
    reset_dut(1);
    idle(1);
    check("tag_err_cleared", 64'(tag_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
